// File: rtl/memory_access_stage_if.sv
// Data-bus bundle between the memory-access stage (master) and the memory/peripheral fabric (slave).
// Single-beat stb/ack handshake; addr is always word aligned, sel picks the byte lanes.
interface memory_access_stage_if;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;

    modport master (
        output stb, we, addr, wdat, sel,
        input  ack, rdat
    );

    modport slave (
        input  stb, we, addr, wdat, sel,
        output ack, rdat
    );
endinterface

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: runs loads/stores as single bus transactions and forwards results to writeback.
// Optional macro MISALIGN_TRAP_EN: misaligned halfword/word accesses fault in one cycle without touching the bus.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OPCODE_W       = 11,
    parameter int LOAD_BIT       = 2,
    parameter int STORE_BIT      = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [31:0]         i_y,
    input  logic [31:0]         i_rs2,
    input  logic [2:0]          i_funct3,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [4:0]          i_rd_addr,
    input  logic [31:0]         i_rd,
    input  logic                i_rd_valid,
    input  logic                i_wr_rd,
    input  logic [31:0]         i_pc,
    input  logic                i_ce,
    input  logic                i_stall_from_alu,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic [4:0]          o_rd_addr,
    output logic [31:0]         o_rd,
    output logic                o_rd_valid,
    output logic                o_wr_rd,
    output logic [31:0]         o_pc,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic [2:0]          o_funct3,
    output logic                o_bus_err,
    output logic                o_ce,
    output logic                o_stall,
    output logic                o_flush,
    memory_access_stage_if.master bus
);
    typedef enum logic {IDLE, BUS} state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    function automatic logic [3:0] store_sel(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_dat(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] a,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        sh = d >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            3'b010:  return sh;
            default: return 32'd0;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [7:0]            timeout_q, timeout_d;
    logic                  stb_q, stb_d, we_q, we_d;
    logic [31:0]           addr_q, addr_d, wdat_q, wdat_d;
    logic [3:0]            sel_q, sel_d;
    logic [4:0]            ctx_rd_addr_q, ctx_rd_addr_d;
    logic [31:0]           ctx_pc_q, ctx_pc_d, ctx_rd_q, ctx_rd_d;
    logic [OPCODE_W-1:0]   ctx_opcode_q, ctx_opcode_d;
    logic [2:0]            ctx_funct3_q, ctx_funct3_d;
    logic [1:0]            ctx_off_q, ctx_off_d;
    logic                  ctx_load_q, ctx_load_d;
    logic                  flush_seen_q, flush_seen_d;
    logic                  pend_q, pend_d, pend_valid_q, pend_valid_d;
    logic                  pend_wr_q, pend_wr_d, pend_err_q, pend_err_d;
    logic [31:0]           pend_rd_q, pend_rd_d;
    logic [4:0]            out_rd_addr_q, out_rd_addr_d;
    logic [31:0]           out_rd_q, out_rd_d, out_pc_q, out_pc_d;
    logic                  out_rd_valid_q, out_rd_valid_d, out_wr_rd_q, out_wr_rd_d;
    logic [OPCODE_W-1:0]   out_opcode_q, out_opcode_d;
    logic [2:0]            out_funct3_q, out_funct3_d;
    logic                  out_bus_err_q, out_bus_err_d, out_ce_q, out_ce_d;

    logic        mem_op, misalign, tmo_hit, emit, emit_ctx;
    logic        res_valid, res_wr, res_err;
    logic [31:0] res_rd;
    logic [7:0]  tmo_next;
    logic        unused_inputs;

    // The execute stage's own memory-op flag duplicates the opcode decode below.
    assign unused_inputs = ^{i_stall_from_alu, 1'b0};

    assign mem_op   = i_ce & (i_opcode[LOAD_BIT] | i_opcode[STORE_BIT]);
`ifdef MISALIGN_TRAP_EN
    assign misalign = ((i_funct3[1:0] == 2'b01) & i_y[0]) |
                      ((i_funct3[1:0] == 2'b10) & (i_y[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign tmo_next = timeout_q + 8'd1;
    assign tmo_hit  = (state_q == BUS) & ~bus.ack & (tmo_next == TMO);

    // A held result also stalls upstream so it cannot collide with a newly presented instruction.
    assign o_stall = i_stall | ((state_q == IDLE) & pend_q) |
                     ((state_q == IDLE) & mem_op & ~misalign & ~i_flush) |
                     ((state_q == BUS) & ~bus.ack);
    assign o_flush = i_flush;

    always_comb begin
        state_d        = state_q;
        timeout_d      = timeout_q;
        stb_d          = stb_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdat_d         = wdat_q;
        sel_d          = sel_q;
        ctx_rd_addr_d  = ctx_rd_addr_q;
        ctx_pc_d       = ctx_pc_q;
        ctx_rd_d       = ctx_rd_q;
        ctx_opcode_d   = ctx_opcode_q;
        ctx_funct3_d   = ctx_funct3_q;
        ctx_off_d      = ctx_off_q;
        ctx_load_d     = ctx_load_q;
        flush_seen_d   = flush_seen_q;
        pend_d         = pend_q;
        pend_rd_d      = pend_rd_q;
        pend_valid_d   = pend_valid_q;
        pend_wr_d      = pend_wr_q;
        pend_err_d     = pend_err_q;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_d       = out_rd_q;
        out_rd_valid_d = out_rd_valid_q;
        out_wr_rd_d    = out_wr_rd_q;
        out_pc_d       = out_pc_q;
        out_opcode_d   = out_opcode_q;
        out_funct3_d   = out_funct3_q;
        out_bus_err_d  = out_bus_err_q;
        out_ce_d       = 1'b0;
        emit           = 1'b0;
        emit_ctx       = 1'b0;
        res_rd         = i_rd;
        res_valid      = i_rd_valid;
        res_wr         = i_wr_rd;
        res_err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    if (!i_stall) begin
                        emit      = 1'b1;
                        emit_ctx  = 1'b1;
                        res_rd    = pend_rd_q;
                        res_valid = pend_valid_q;
                        res_wr    = pend_wr_q;
                        res_err   = pend_err_q;
                        pend_d    = 1'b0;
                    end
                end else if (!i_stall && !i_flush) begin
                    if (mem_op && misalign) begin
                        emit      = 1'b1;
                        res_valid = 1'b0;
                        res_wr    = 1'b0;
                        res_err   = 1'b1;
                    end else if (mem_op) begin
                        state_d       = BUS;
                        timeout_d     = 8'd0;
                        flush_seen_d  = 1'b0;
                        stb_d         = 1'b1;
                        we_d          = i_opcode[STORE_BIT];
                        addr_d        = {i_y[31:2], 2'b00};
                        wdat_d        = store_dat(i_funct3, i_rs2);
                        sel_d         = store_sel(i_funct3, i_y[1:0]);
                        ctx_rd_addr_d = i_rd_addr;
                        ctx_pc_d      = i_pc;
                        ctx_rd_d      = i_rd;
                        ctx_opcode_d  = i_opcode;
                        ctx_funct3_d  = i_funct3;
                        ctx_off_d     = i_y[1:0];
                        ctx_load_d    = i_opcode[LOAD_BIT];
                    end else if (i_ce) begin
                        emit = 1'b1;
                    end
                end
            end
            BUS: begin
                if (i_flush) flush_seen_d = 1'b1;
                if (bus.ack || tmo_hit) begin
                    state_d   = IDLE;
                    stb_d     = 1'b0;
                    timeout_d = 8'd0;
                    res_rd    = (bus.ack && ctx_load_q) ?
                                load_extract(bus.rdat, ctx_off_q, ctx_funct3_q) : ctx_rd_q;
                    res_valid = bus.ack & ctx_load_q;
                    res_wr    = bus.ack & ctx_load_q & (ctx_rd_addr_q != 5'd0);
                    res_err   = ~bus.ack;
                    // A flushed access still finishes on the bus, but its result never reaches writeback.
                    if (!(flush_seen_q || i_flush)) begin
                        if (i_stall) begin
                            pend_d       = 1'b1;
                            pend_rd_d    = res_rd;
                            pend_valid_d = res_valid;
                            pend_wr_d    = res_wr;
                            pend_err_d   = res_err;
                        end else begin
                            emit     = 1'b1;
                            emit_ctx = 1'b1;
                        end
                    end
                end else begin
                    timeout_d = tmo_next;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            out_ce_d       = 1'b1;
            out_rd_d       = res_rd;
            out_rd_valid_d = res_valid;
            out_wr_rd_d    = res_wr;
            out_bus_err_d  = res_err;
            if (emit_ctx) begin
                out_rd_addr_d = ctx_rd_addr_q;
                out_pc_d      = ctx_pc_q;
                out_opcode_d  = ctx_opcode_q;
                out_funct3_d  = ctx_funct3_q;
            end else begin
                out_rd_addr_d = i_rd_addr;
                out_pc_d      = i_pc;
                out_opcode_d  = i_opcode;
                out_funct3_d  = i_funct3;
            end
        end
    end

    // State / output register boundary
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            timeout_q      <= 8'd0;
            stb_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'd0;
            wdat_q         <= 32'd0;
            sel_q          <= 4'd0;
            ctx_rd_addr_q  <= 5'd0;
            ctx_pc_q       <= 32'd0;
            ctx_rd_q       <= 32'd0;
            ctx_opcode_q   <= '0;
            ctx_funct3_q   <= 3'd0;
            ctx_off_q      <= 2'd0;
            ctx_load_q     <= 1'b0;
            flush_seen_q   <= 1'b0;
            pend_q         <= 1'b0;
            pend_rd_q      <= 32'd0;
            pend_valid_q   <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_err_q     <= 1'b0;
            out_rd_addr_q  <= 5'd0;
            out_rd_q       <= 32'd0;
            out_rd_valid_q <= 1'b0;
            out_wr_rd_q    <= 1'b0;
            out_pc_q       <= 32'd0;
            out_opcode_q   <= '0;
            out_funct3_q   <= 3'd0;
            out_bus_err_q  <= 1'b0;
            out_ce_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timeout_q      <= timeout_d;
            stb_q          <= stb_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdat_q         <= wdat_d;
            sel_q          <= sel_d;
            ctx_rd_addr_q  <= ctx_rd_addr_d;
            ctx_pc_q       <= ctx_pc_d;
            ctx_rd_q       <= ctx_rd_d;
            ctx_opcode_q   <= ctx_opcode_d;
            ctx_funct3_q   <= ctx_funct3_d;
            ctx_off_q      <= ctx_off_d;
            ctx_load_q     <= ctx_load_d;
            flush_seen_q   <= flush_seen_d;
            pend_q         <= pend_d;
            pend_rd_q      <= pend_rd_d;
            pend_valid_q   <= pend_valid_d;
            pend_wr_q      <= pend_wr_d;
            pend_err_q     <= pend_err_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_q       <= out_rd_d;
            out_rd_valid_q <= out_rd_valid_d;
            out_wr_rd_q    <= out_wr_rd_d;
            out_pc_q       <= out_pc_d;
            out_opcode_q   <= out_opcode_d;
            out_funct3_q   <= out_funct3_d;
            out_bus_err_q  <= out_bus_err_d;
            out_ce_q       <= out_ce_d;
        end
    end

    assign bus.stb    = stb_q;
    assign bus.we     = we_q;
    assign bus.addr   = addr_q;
    assign bus.wdat   = wdat_q;
    assign bus.sel    = sel_q;
    assign o_rd_addr  = out_rd_addr_q;
    assign o_rd       = out_rd_q;
    assign o_rd_valid = out_rd_valid_q;
    assign o_wr_rd    = out_wr_rd_q;
    assign o_pc       = out_pc_q;
    assign o_opcode   = out_opcode_q;
    assign o_funct3   = out_funct3_q;
    assign o_bus_err  = out_bus_err_q;
    assign o_ce       = out_ce_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed + randomized bench for memory_access_stage with a spec-level reference model for lanes and load data.
module tb_memory_access_stage;
    localparam int OW = 11;
    localparam logic [OW-1:0] OP_ALU   = 11'b000_0000_0001;
    localparam logic [OW-1:0] OP_LOAD  = 11'b000_0000_0100;
    localparam logic [OW-1:0] OP_STORE = 11'b000_0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_y, i_rs2, i_rd, i_pc;
    logic [2:0]    i_funct3;
    logic [OW-1:0] i_opcode;
    logic [4:0]    i_rd_addr;
    logic          i_rd_valid, i_wr_rd, i_ce, i_stall_from_alu, i_stall, i_flush;
    logic [4:0]    o_rd_addr;
    logic [31:0]   o_rd, o_pc;
    logic          o_rd_valid, o_wr_rd, o_bus_err, o_ce, o_stall, o_flush;
    logic [OW-1:0] o_opcode;
    logic [2:0]    o_funct3;

    int n_checks = 0;
    int n_pass   = 0;

    memory_access_stage_if bus_if ();

    memory_access_stage #(.TIMEOUT_CYCLES(4), .OPCODE_W(OW), .LOAD_BIT(2), .STORE_BIT(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
        .i_opcode(i_opcode), .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_rd_valid(i_rd_valid),
        .i_wr_rd(i_wr_rd), .i_pc(i_pc), .i_ce(i_ce), .i_stall_from_alu(i_stall_from_alu),
        .i_stall(i_stall), .i_flush(i_flush), .o_rd_addr(o_rd_addr), .o_rd(o_rd),
        .o_rd_valid(o_rd_valid), .o_wr_rd(o_wr_rd), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_funct3(o_funct3), .o_bus_err(o_bus_err), .o_ce(o_ce), .o_stall(o_stall),
        .o_flush(o_flush), .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input logic [2:0] f3);
        logic [31:0] v;
        int unsigned b, h;
        v = w >> (8 * a);
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            3'd2:    return v;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_sel(input int a, input logic [2:0] f3);
        logic [3:0] s;
        int sz;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        s = 4'd0;
        if (sz == 4) return 4'hF;
        for (int i = a; i < 4 && i < a + sz; i++) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_dat(input logic [31:0] rs2, input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 32'(rs2[7:0]) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return 32'(rs2[15:0]) * 32'h0001_0001;
        return rs2;
    endfunction

    task automatic issue(input bit is_load, input logic [2:0] f3, input logic [31:0] y,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] pc,
                         output int stalls);
        i_ce = 1'b1; i_opcode = is_load ? OP_LOAD : OP_STORE; i_stall_from_alu = 1'b1;
        i_funct3 = f3; i_y = y; i_rs2 = rs2; i_rd_addr = rd; i_pc = pc;
        i_rd = 32'h5A5A_0000; i_rd_valid = 1'b0; i_wr_rd = is_load;
        #1;
        stalls = o_stall ? 1 : 0;
        tick();
        i_ce = 1'b0; i_opcode = '0; i_stall_from_alu = 1'b0;
    endtask

    task automatic mem_txn(input string tag, input bit is_load, input logic [2:0] f3,
                           input logic [31:0] y, input logic [31:0] rs2, input logic [4:0] rd,
                           input int delay, input logic [31:0] rdat);
        int stalls;
        logic [31:0] pc;
        pc = $urandom;
        issue(is_load, f3, y, rs2, rd, pc, stalls);
        chk({tag, "_stb"}, 32'(bus_if.stb), 32'd1);
        chk({tag, "_addr"}, bus_if.addr, {y[31:2], 2'b00});
        chk({tag, "_we"}, 32'(bus_if.we), 32'(!is_load));
        chk({tag, "_sel"}, 32'(bus_if.sel), 32'(ref_sel(int'(y[1:0]), f3)));
        if (!is_load) chk({tag, "_wdat"}, bus_if.wdat, ref_dat(rs2, f3));
        for (int k = 0; k < delay; k++) begin
            #1;
            if (o_stall) stalls++;
            tick();
        end
        chk({tag, "_stb_held"}, 32'(bus_if.stb), 32'd1);
        bus_if.ack = 1'b1; bus_if.rdat = rdat;
        #1;
        chk({tag, "_stall_on_ack"}, 32'(o_stall), 32'd0);
        tick();
        bus_if.ack = 1'b0; bus_if.rdat = $urandom;
        chk({tag, "_stb_drop"}, 32'(bus_if.stb), 32'd0);
        chk({tag, "_ce"}, 32'(o_ce), 32'd1);
        chk({tag, "_wr_rd"}, 32'(o_wr_rd), 32'(is_load && rd != 5'd0));
        chk({tag, "_err"}, 32'(o_bus_err), 32'd0);
        chk({tag, "_pc"}, o_pc, pc);
        chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'(rd));
        chk({tag, "_funct3"}, 32'(o_funct3), 32'(f3));
        if (is_load) begin
            chk({tag, "_rd"}, o_rd, ref_load(rdat, int'(y[1:0]), f3));
            chk({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd1);
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(delay + 1));
        tick();
        chk({tag, "_ce_pulse"}, 32'(o_ce), 32'd0);
    endtask

    task automatic pass_txn(input string tag, input logic [31:0] rd, input logic [4:0] rda,
                            input logic wr);
        i_ce = 1'b1; i_opcode = OP_ALU; i_rd = rd; i_rd_addr = rda; i_wr_rd = wr;
        i_rd_valid = 1'b1; i_pc = 32'h0000_1000 + 32'(rda);
        #1;
        chk({tag, "_stall"}, 32'(o_stall), 32'd0);
        tick();
        i_ce = 1'b0; i_opcode = '0;
        chk({tag, "_ce"}, 32'(o_ce), 32'd1);
        chk({tag, "_rd"}, o_rd, rd);
        chk({tag, "_wr_rd"}, 32'(o_wr_rd), 32'(wr));
        chk({tag, "_pc"}, o_pc, 32'h0000_1000 + 32'(rda));
        chk({tag, "_opcode"}, 32'(o_opcode), 32'(OP_ALU));
        chk({tag, "_no_stb"}, 32'(bus_if.stb), 32'd0);
    endtask

    initial begin
        int stalls, cnt, op, dly;
        logic [2:0] f3;
        logic [31:0] y;
        logic [2:0] ld_f3 [7];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

        rst = 1'b1; i_y = '0; i_rs2 = '0; i_rd = '0; i_pc = '0; i_funct3 = '0; i_opcode = '0;
        i_rd_addr = '0; i_rd_valid = 1'b0; i_wr_rd = 1'b0; i_ce = 1'b0; i_stall_from_alu = 1'b0;
        i_stall = 1'b0; i_flush = 1'b0; bus_if.ack = 1'b0; bus_if.rdat = '0;
        tick(); tick();
        chk("rst_ce", 32'(o_ce), 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_stb", 32'(bus_if.stb), 32'd0);
        chk("rst_err", 32'(o_bus_err), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        rst = 1'b0;
        tick();

        mem_txn("lw", 1'b1, 3'd2, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF);
        mem_txn("lb", 1'b1, 3'd0, 32'h103, 32'h0, 5'd6, 1, 32'h80112233);
        mem_txn("lbu", 1'b1, 3'd4, 32'h103, 32'h0, 5'd7, 0, 32'h80112233);
        mem_txn("lhu", 1'b1, 3'd5, 32'h102, 32'h0, 5'd0, 2, 32'h80112233);
        chk("lhu_value", o_rd, 32'h0000_8011);
        mem_txn("sb", 1'b0, 3'd0, 32'h201, 32'h0000_00AB, 5'd3, 1, 32'h0);
        chk("sb_wr_rd", 32'(o_wr_rd), 32'd0);
`ifndef MISALIGN_TRAP_EN
        mem_txn("sh_a3", 1'b0, 3'd1, 32'h203, 32'h0000_BEEF, 5'd3, 0, 32'h0);
`endif
        pass_txn("add", 32'h1234, 5'd9, 1'b1);
        pass_txn("add2", 32'hFFFF_0001, 5'd0, 1'b0);

        // Timeout: no ack at all.
        issue(1'b1, 3'd2, 32'h300, 32'h0, 5'd4, 32'h300, stalls);
        cnt = 0;
        while (bus_if.stb && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("tmo_stb_cycles", 32'(cnt), 32'd4);
        chk("tmo_err", 32'(o_bus_err), 32'd1);
        chk("tmo_wr_rd", 32'(o_wr_rd), 32'd0);
        chk("tmo_ce", 32'(o_ce), 32'd1);
        tick();
        chk("tmo_ce_pulse", 32'(o_ce), 32'd0);

        // Flush during BUS: store still completes on the bus, nothing retires.
        issue(1'b0, 3'd2, 32'h400, 32'h1122_3344, 5'd2, 32'h400, stalls);
        i_flush = 1'b1;
        #1;
        chk("flush_out", 32'(o_flush), 32'd1);
        tick();
        i_flush = 1'b0;
        chk("flush_bus_stb", 32'(bus_if.stb), 32'd1);
        chk("flush_bus_we", 32'(bus_if.we), 32'd1);
        chk("flush_bus_wdat", bus_if.wdat, 32'h1122_3344);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        chk("flush_bus_stb_drop", 32'(bus_if.stb), 32'd0);
        chk("flush_bus_ce", 32'(o_ce), 32'd0);
        tick();
        chk("flush_bus_ce2", 32'(o_ce), 32'd0);

        // Flush in IDLE with a memory op presented: no request.
        i_ce = 1'b1; i_opcode = OP_LOAD; i_y = 32'h500; i_funct3 = 3'd2; i_flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(o_stall), 32'd0);
        tick();
        i_ce = 1'b0; i_opcode = '0; i_flush = 1'b0;
        chk("flush_idle_stb", 32'(bus_if.stb), 32'd0);
        chk("flush_idle_ce", 32'(o_ce), 32'd0);

        // Stray ack outside BUS is ignored.
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        chk("stray_ack_ce", 32'(o_ce), 32'd0);

        // Downstream stall during BUS: result is held until the stall drops.
        issue(1'b1, 3'd2, 32'h600, 32'h0, 5'd5, 32'h600, stalls);
        i_stall = 1'b1; bus_if.ack = 1'b1; bus_if.rdat = 32'hCAFE_F00D;
        #1;
        chk("stall_o_stall", 32'(o_stall), 32'd1);
        tick();
        bus_if.ack = 1'b0;
        chk("stall_stb_drop", 32'(bus_if.stb), 32'd0);
        chk("stall_ce_held", 32'(o_ce), 32'd0);
        tick();
        chk("stall_ce_held2", 32'(o_ce), 32'd0);
        i_stall = 1'b0;
        tick();
        chk("stall_release_ce", 32'(o_ce), 32'd1);
        chk("stall_release_rd", o_rd, 32'hCAFE_F00D);
        chk("stall_release_wr", 32'(o_wr_rd), 32'd1);
        tick();
        chk("stall_release_pulse", 32'(o_ce), 32'd0);

        // Reset in the middle of a bus access.
        issue(1'b1, 3'd2, 32'h700, 32'h0, 5'd1, 32'h700, stalls);
        chk("rst_mid_stb_pre", 32'(bus_if.stb), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_stb", 32'(bus_if.stb), 32'd0);
        chk("rst_mid_ce", 32'(o_ce), 32'd0);
        tick();
        chk("rst_mid_idle", 32'(bus_if.stb), 32'd0);

`ifdef MISALIGN_TRAP_EN
        i_ce = 1'b1; i_opcode = OP_LOAD; i_y = 32'h102; i_funct3 = 3'd2; i_rd_addr = 5'd3;
        tick();
        i_ce = 1'b0; i_opcode = '0;
        chk("mis_lw_stb", 32'(bus_if.stb), 32'd0);
        chk("mis_lw_err", 32'(o_bus_err), 32'd1);
        chk("mis_lw_wr", 32'(o_wr_rd), 32'd0);
        chk("mis_lw_ce", 32'(o_ce), 32'd1);
        tick();
`else
        mem_txn("lw_a2", 1'b1, 3'd2, 32'h102, 32'h0, 5'd3, 1, 32'h8011_2233);
`endif

        for (int it = 0; it < 24; it++) begin
            op  = int'($urandom_range(0, 2));
            dly = int'($urandom_range(0, 3));
            y   = $urandom;
`ifdef MISALIGN_TRAP_EN
            y[1:0] = 2'b00;
`endif
            if (op == 0) begin
                f3 = ld_f3[$urandom_range(0, 6)];
                mem_txn("rnd_ld", 1'b1, f3, y, 32'h0, 5'($urandom), dly, $urandom);
            end else if (op == 1) begin
                f3 = 3'($urandom_range(0, 2));
                mem_txn("rnd_st", 1'b0, f3, y, $urandom, 5'($urandom), dly, 32'h0);
            end else begin
                pass_txn("rnd_alu", $urandom, 5'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result as the data address, rs2 as store data, and funct3/opcode. Non-memory instructions pass through unchanged.
- Runs loads and stores as single bus transactions (stb/ack handshake), stalling upstream until they complete. Delivers aligned, sign/zero-extended load data and writeback controls to the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUS without ack before the access is aborted as a bus error (1..255).
- OPCODE_W, 11, width of the one-hot opcode bus (same encoding as the execute stage).
- LOAD_BIT, 2, index of LOAD in the opcode bus.
- STORE_BIT, 3, index of STORE in the opcode bus.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- Pipeline inputs from execute:
  - i_y  in  32  ALU result / data address
  - i_rs2  in  32  store data
  - i_funct3  in  3  access size/sign
  - i_opcode  in  OPCODE_W  one-hot opcode
  - i_rd_addr  in  5  destination register
  - i_rd  in  32  execute-stage rd value
  - i_rd_valid  in  1  i_rd valid
  - i_wr_rd  in  1  write enable
  - i_pc  in  32  instruction PC
  - i_ce  in  1  stage clock enable
  - i_stall_from_alu  in  1  memory op present
  - i_stall  in  1  downstream stall
  - i_flush  in  1  flush this stage
- Pipeline outputs to writeback:
  - o_rd_addr  out  5  destination register
  - o_rd  out  32  final rd value
  - o_rd_valid  out  1  o_rd valid
  - o_wr_rd  out  1  write enable
  - o_pc  out  32  PC
  - o_opcode  out  OPCODE_W  opcode
  - o_funct3  out  3  funct3
  - o_bus_err  out  1  access fault
  - o_ce  out  1  next-stage clock enable
  - o_stall  out  1  stall request to upstream
  - o_flush  out  1  flush upstream (= i_flush)
- Data bus:
  - o_wb_stb  out  1  request strobe
  - o_wb_we  out  1  write
  - o_wb_addr  out  32  word-aligned address
  - o_wb_dat  out  32  write data
  - o_wb_sel  out  4  byte enables
  - i_wb_ack  in  1  transfer complete
  - i_wb_dat  in  32  read data

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs 0.
- FSM states: IDLE, BUS.
- mem_op = i_ce & (i_opcode[LOAD_BIT] | i_opcode[STORE_BIT]).
- IDLE, non-memory instruction, i_ce=1, !i_stall, !i_flush:
  - 1-cycle pass-through; o_rd=i_rd, o_ce<=1.
- IDLE, mem_op, !i_stall, !i_flush:
  - Latch address, data, sel and funct3; go to BUS; o_wb_stb=1 from the next cycle.
- BUS:
  - o_wb_stb held 1, all bus outputs stable until ack.
  - On i_wb_ack: o_wb_stb<=0, o_ce<=1, state<=IDLE, outputs registered. Ack is ignored outside BUS.
  - Load access latency = ack cycle + 1.
- o_stall (combinational) = i_stall | (IDLE & mem_op & !i_flush) | (BUS & !i_wb_ack).
- o_ce <= 0 on any cycle no instruction completes (bubble).
- i_stall=1: all output registers hold; o_ce<=0. A BUS transaction still completes; its result is held internally and emitted when i_stall drops.
- Store byte lanes (a = address[1:0]):
  - SB: sel = 0001<<a, dat = {4{rs2[7:0]}}.
  - SH: sel = 0011<<a, dat = {2{rs2[15:0]}}.
  - SW: sel = 1111, dat = rs2.
- Address/wire rules: o_wb_addr = {y[31:2],2'b00}; o_wb_we = store.
- Load data: shift i_wb_dat right by 8*a, then:
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: full word.
  - Reserved funct3 (011, 110, 111) returns 0.
- Writeback controls:
  - Load: o_rd_valid=1, o_wr_rd = (rd_addr != 0).
  - Store: o_wr_rd=0.
- Timeout:
  - Counter increments each BUS cycle without ack.
  - At TIMEOUT_CYCLES: abort (stb<=0), o_bus_err<=1, o_wr_rd<=0, o_ce<=1, state IDLE.
  - Ack on the same cycle as the timeout wins.
- Flush:
  - i_flush in IDLE: no request is issued; o_ce<=0.
  - i_flush in BUS: the bus transaction still completes (stores commit), but o_ce<=0 at completion and the result is dropped.
- Reset mid-BUS drops stb on the next edge with no completion.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A halfword access with a[0]=1, or a word access with a!=0, issues no bus request.
  - Completes in 1 cycle with o_bus_err=1 and o_wr_rd=0.
- Undefined: the low address bits are used only for lane steering. Misaligned halfwords at a=3 use sel 1000.

Test Plan:
- LW y=0x100, ack after 3 cycles, i_wb_dat=0xDEADBEEF -> o_wb_addr=0x100, sel=1111, o_stall=1 for 4 cycles, o_rd=0xDEADBEEF, o_ce pulse once.
- LB y=0x103, i_wb_dat=0x80112233 -> o_rd=0xFFFFFF80; LBU -> 0x00000080; LHU y=0x102 -> 0x00008011.
- SB y=0x201 rs2=0x000000AB -> o_wb_we=1, sel=0010, o_wb_dat=0xABABABAB, o_wr_rd=0.
- ADD passthrough i_rd=0x1234, i_ce=1 -> o_rd=0x1234 next cycle, no o_wb_stb, o_stall=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> stb dropped after 4 BUS cycles, o_bus_err=1, o_wr_rd=0.
- SW with i_flush asserted in BUS, ack at cycle 2 -> write completes on bus, o_ce stays 0. With MISALIGN_TRAP_EN: LW y=0x102 -> no stb, o_bus_err=1.
